// File: rtl/chess_piece_judge_if.sv
// Pixel-to-stone judge interface.
// Groups the per-pixel query (x, y, row, col) and the registered answer
// (judge, rim) exchanged between the board renderer and the judge.
//   master : board renderer side, drives the pixel query, reads the answer
//   slave  : judge side, reads the pixel query, drives the answer
interface chess_piece_judge_if;
    logic [9:0] x;      // pixel column 0..639
    logic [9:0] y;      // pixel row 0..479
    logic [3:0] col;    // intersection column, 15 = outside grid
    logic [3:0] row;    // intersection row, 15 = outside grid
    logic       judge;  // pixel lies inside the stone disk
    logic       rim;    // pixel lies on the outer rim of the disk

    modport master (
        output x, y, col, row,
        input  judge, rim
    );

    modport slave (
        input  x, y, col, row,
        output judge, rim
    );
endinterface

// File: rtl/chess_piece_judge.sv
// chess_piece_judge
// Decides, for every scanned pixel, whether it falls inside the round stone
// drawn at the given board intersection and whether it sits on the stone's
// outer rim. Results are registered with a latency of one pixel clock.
// Ports:
//   clk : pixel clock (single domain)
//   rst : synchronous active-low reset, clears judge/rim
//   pix : chess_piece_judge_if.slave
//         inputs  x[9:0], y[9:0], col[3:0], row[3:0]
//         outputs judge (inside disk), rim (on outer rim), both registered
module chess_piece_judge #(
    parameter int ORIGIN_X  = 102,
    parameter int ORIGIN_Y  = 23,
    parameter int GRID_SIZE = 31,
    parameter int RADIUS    = 13,
    parameter int RIM_WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    chess_piece_judge_if.slave   pix
);

    // Bits needed to hold an offset magnitude that passed the box test,
    // and the width of the sum of two such squares.
    localparam int RW  = $clog2(RADIUS + 1);
    localparam int D2W = 2 * RW + 1;

    localparam logic [11:0]    RADIUS_C  = 12'(RADIUS);
    localparam logic [D2W-1:0] OUTER2_C  = D2W'(RADIUS * RADIUS);
    localparam logic [D2W-1:0] INNER2_C  = D2W'((RADIUS - RIM_WIDTH) * (RADIUS - RIM_WIDTH));
    localparam logic [3:0]     OFF_GRID  = 4'd15;

    // Absolute value of a 12-bit two's-complement offset.
    function automatic logic [11:0] abs12(input logic signed [11:0] v);
        logic [11:0] r;
        r = v[11] ? 12'(-v) : 12'(v);
        return r;
    endfunction

    // Square of a box-limited magnitude, widened so the sum cannot wrap.
    function automatic logic [D2W-1:0] sq(input logic [RW-1:0] v);
        logic [D2W-1:0] w;
        w = D2W'(v);
        return D2W'(w * w);
    endfunction

    logic [11:0]        cx_s;
    logic [11:0]        cy_s;
    logic signed [11:0] dx_s;
    logic signed [11:0] dy_s;
    logic [11:0]        ax_s;
    logic [11:0]        ay_s;
    logic               near_s;
    logic [RW-1:0]      axn_s;
    logic [RW-1:0]      ayn_s;
    logic [D2W-1:0]     d2_s;
    logic               valid_idx_s;
    logic               inside_s;
    logic               on_rim_s;
    logic               judge_r;
    logic               rim_r;

    // Centre, offsets and distance test for the current pixel.
    always_comb begin
        cx_s   = 12'(ORIGIN_X) + 12'({8'd0, pix.col}) * 12'(GRID_SIZE);
        cy_s   = 12'(ORIGIN_Y) + 12'({8'd0, pix.row}) * 12'(GRID_SIZE);
        dx_s   = signed'({2'b00, pix.x}) - signed'(cx_s);
        dy_s   = signed'({2'b00, pix.y}) - signed'(cy_s);
        ax_s   = abs12(dx_s);
        ay_s   = abs12(dy_s);
        // Box test first: only magnitudes within RADIUS reach the squarers,
        // which keeps the multipliers RW bits wide.
        near_s = (ax_s <= RADIUS_C) && (ay_s <= RADIUS_C);
        axn_s  = near_s ? ax_s[RW-1:0] : {RW{1'b0}};
        ayn_s  = near_s ? ay_s[RW-1:0] : {RW{1'b0}};
        d2_s   = sq(axn_s) + sq(ayn_s);
        valid_idx_s = (pix.row != OFF_GRID) && (pix.col != OFF_GRID);
        inside_s    = valid_idx_s && near_s && (d2_s <= OUTER2_C);
        on_rim_s    = inside_s && (d2_s > INNER2_C);
    end

    // Output registers; reset overrides the pixel evaluation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            judge_r <= 1'b0;
            rim_r   <= 1'b0;
        end else begin
            judge_r <= inside_s;
            rim_r   <= on_rim_s;
        end
    end

    assign pix.judge = judge_r;
    assign pix.rim   = rim_r;

endmodule

// File: tb/tb_chess_piece_judge.sv
// Self-checking bench for chess_piece_judge: directed boundary cases,
// a continuous sweep, then randomized pixels against a geometric model.
module tb_chess_piece_judge;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    chess_piece_judge_if bus ();

    chess_piece_judge dut (
        .clk (clk),
        .rst (rst),
        .pix (bus.slave)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Reference: Euclidean distance from the intersection centre.
    function automatic void model(input int xi, input int yi, input int ri, input int ci,
                                  output logic j, output logic r);
        int cx, cy, dd;
        cx = 102 + ci * 31;
        cy = 23 + ri * 31;
        dd = (xi - cx) * (xi - cx) + (yi - cy) * (yi - cy);
        j  = (ri != 15) && (ci != 15) && (dd <= 13 * 13);
        r  = j && (dd > 12 * 12);
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // One pixel per clock: drive on the falling edge, check after the rising edge.
    task automatic step(input int xi, input int yi, input int ri, input int ci,
                        input logic rsti, input logic ej, input logic er,
                        input string tag, input logic chk_rim);
        @(negedge clk);
        bus.x   = 10'(xi);
        bus.y   = 10'(yi);
        bus.row = 4'(ri);
        bus.col = 4'(ci);
        rst     = rsti;
        @(posedge clk);
        #1;
        check({tag, ".judge"}, bus.judge, ej);
        if (chk_rim) check({tag, ".rim"}, bus.rim, er);
    endtask

    initial begin
        logic ej, er;
        int   xi, yi, ri, ci;
        logic rb;
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;
        bus.x   = 10'd0;
        bus.y   = 10'd0;
        bus.row = 4'd0;
        bus.col = 4'd0;

        // Centre under reset, then released.
        step(102, 23, 0, 0, 1'b0, 1'b0, 1'b0, "reset_centre", 1'b1);
        step(102, 23, 0, 0, 1'b1, 1'b1, 1'b0, "centre", 1'b1);

        // Horizontal boundary.
        step(115, 23, 0, 0, 1'b1, 1'b1, 1'b1, "h_dx13", 1'b1);
        step(116, 23, 0, 0, 1'b1, 1'b0, 1'b0, "h_dx14", 1'b1);
        step(89,  23, 0, 0, 1'b1, 1'b1, 1'b1, "h_dxm13", 1'b1);
        step(88,  23, 0, 0, 1'b1, 1'b0, 1'b0, "h_dxm14", 1'b1);

        // Diagonal boundary around (319,240).
        step(328, 249, 7, 7, 1'b1, 1'b1, 1'b1, "diag162", 1'b1);
        step(329, 249, 7, 7, 1'b1, 1'b0, 1'b0, "diag181", 1'b1);
        step(324, 244, 7, 7, 1'b1, 1'b1, 1'b0, "diag41", 1'b1);

        // Far corner around (536,457).
        step(536, 470, 14, 14, 1'b1, 1'b1, 1'b1, "corner_in", 1'b0);
        step(536, 471, 14, 14, 1'b1, 1'b0, 1'b0, "corner_out", 1'b1);

        // Off-grid index at valid centres.
        step(319, 240, 15, 7, 1'b1, 1'b0, 1'b0, "row15", 1'b1);
        step(319, 240, 7, 15, 1'b1, 1'b0, 1'b0, "col15", 1'b1);
        step(566, 488 - 31, 14, 15, 1'b1, 1'b0, 1'b0, "col15b", 1'b1);

        // Mid-frame reset clears outputs within a cycle.
        step(102, 23, 0, 0, 1'b0, 1'b0, 1'b0, "midreset", 1'b1);

        // Continuous sweep along row 0.
        for (int sx = 80; sx <= 130; sx++) begin
            step(sx, 23, 0, 0, 1'b1, (sx >= 89 && sx <= 115), (sx == 89 || sx == 115),
                 $sformatf("sweep_x%0d", sx), 1'b1);
        end

        // Randomized pixels, mostly near an intersection, occasional reset.
        for (int k = 0; k < 600; k++) begin
            ri = int'($urandom_range(15, 0));
            ci = int'($urandom_range(15, 0));
            if ($urandom_range(3, 0) == 0) begin
                xi = int'($urandom_range(639, 0));
                yi = int'($urandom_range(479, 0));
            end else begin
                xi = 102 + (ci % 15) * 31 + int'($urandom_range(32, 0)) - 16;
                yi = 23  + (ri % 15) * 31 + int'($urandom_range(32, 0)) - 16;
                if (yi > 479) yi = 479;
            end
            rb = ($urandom_range(19, 0) != 0);
            model(xi, yi, ri, ci, ej, er);
            if (!rb) begin
                ej = 1'b0;
                er = 1'b0;
            end
            step(xi, yi, ri, ci, rb, ej, er,
                 $sformatf("rand%0d_x%0d_y%0d_r%0d_c%0d", k, xi, yi, ri, ci), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
